global_fsm_ln_iembed_ctrl: RTL and testbench

- Global control FSM for the layer-norm/input-embed task group.
- Accepts the host ap_ctrl_hs handshake and latches the kernel scalars (input mmap offset, seq_len).
- Broadcasts a one-cycle start to NUM_TASKS per-task FSMs (e.g. the input_loader task FSM) and waits until every task FSM reports done.
- Then issues a one-cycle global done that returns all task FSMs to idle, and completes the host handshake.

---
 rtl/global_fsm_ln_iembed_ctrl.sv | 107 ++++++++++
 tb/tb_global_fsm_ln_iembed_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_fsm_ln_iembed_ctrl.sv
// Global control FSM for the layer-norm / input-embed task group.
// Optional run-length counter: define GLOBAL_FSM_PERF_CNT_EN.
module global_fsm_ln_iembed_ctrl #(
  parameter int NUM_TASKS = 4,
  parameter int OFFSET_W  = 64,
  parameter int LEN_W     = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_idle,
  input  logic [OFFSET_W-1:0]  s_input_mmap_offset,
  input  logic [LEN_W-1:0]     s_seq_len,
  output logic [OFFSET_W-1:0]  global_fsm_s_input_mmap_offset,
  output logic [LEN_W-1:0]     global_fsm_s_seq_len,
  output logic                 global_fsm_ap_start,
  output logic                 global_fsm_ap_done,
  input  logic [NUM_TASKS-1:0] task_is_done,
  output logic [63:0]          perf_cycles
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LAUNCH = 2'b01,
    S_WAIT   = 2'b11,
    S_FINISH = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_done_all;
  logic                 w_accept;
  logic [OFFSET_W-1:0]  r_offset;
  logic [LEN_W-1:0]     r_seq_len;

  assign w_done_all = &task_is_done;
  assign w_accept   = (r_state == S_IDLE) && ap_start;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (ap_start) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (w_done_all) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Every output is a pure decode of the state register.
  assign ap_idle             = (r_state == S_IDLE);
  assign ap_ready            = (r_state == S_LAUNCH);
  assign global_fsm_ap_start = (r_state == S_LAUNCH);
  assign ap_done             = (r_state == S_FINISH);
  assign global_fsm_ap_done  = (r_state == S_FINISH);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_offset  <= '0;
      r_seq_len <= '0;
    end else if (w_accept) begin
      r_offset  <= s_input_mmap_offset;
      r_seq_len <= s_seq_len;
    end
  end

  assign global_fsm_s_input_mmap_offset = r_offset;
  assign global_fsm_s_seq_len           = r_seq_len;

`ifdef GLOBAL_FSM_PERF_CNT_EN
  logic [63:0] r_cnt;
  logic [63:0] r_perf;

  // +1 on load covers the final WAIT cycle that sees done_all.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_cnt  <= '0;
      r_perf <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_LAUNCH ||
                   r_state == S_WAIT) begin
        r_cnt <= r_cnt + 64'd1;
      end
      if (r_state == S_WAIT && w_done_all) begin
        r_perf <= r_cnt + 64'd1;
      end
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_global_fsm_ln_iembed_ctrl.sv
// Directed bench for global_fsm_ln_iembed_ctrl.
// Also runs a NUM_TASKS=1 instance for back-to-back starts.
module tb_global_fsm_ln_iembed_ctrl;

  localparam logic [4:0] ST_IDLE   = 5'b10000;
  localparam logic [4:0] ST_LAUNCH = 5'b01100;
  localparam logic [4:0] ST_WAIT   = 5'b00000;
  localparam logic [4:0] ST_FINISH = 5'b00011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] off;
  logic [31:0] len;
  logic [3:0]  tdone;
  logic        ready, done, idle, gstart, gdone;
  logic [63:0] o_off;
  logic [31:0] o_len;
  logic [63:0] perf;

  logic        s1_start;
  logic [0:0]  s1_tdone;
  logic        r1_ready, r1_done, r1_idle;
  logic        r1_gstart, r1_gdone;
  logic [63:0] r1_off;
  logic [31:0] r1_len;
  logic [63:0] r1_perf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  global_fsm_ln_iembed_ctrl #(.NUM_TASKS(4)) u_dut (
    .ap_clk                         (clk),
    .ap_rst                         (rst),
    .ap_start                       (start),
    .ap_ready                       (ready),
    .ap_done                        (done),
    .ap_idle                        (idle),
    .s_input_mmap_offset            (off),
    .s_seq_len                      (len),
    .global_fsm_s_input_mmap_offset (o_off),
    .global_fsm_s_seq_len           (o_len),
    .global_fsm_ap_start            (gstart),
    .global_fsm_ap_done             (gdone),
    .task_is_done                   (tdone),
    .perf_cycles                    (perf)
  );

  global_fsm_ln_iembed_ctrl #(.NUM_TASKS(1)) u_dut1 (
    .ap_clk                         (clk),
    .ap_rst                         (rst),
    .ap_start                       (s1_start),
    .ap_ready                       (r1_ready),
    .ap_done                        (r1_done),
    .ap_idle                        (r1_idle),
    .s_input_mmap_offset            (off),
    .s_seq_len                      (len),
    .global_fsm_s_input_mmap_offset (r1_off),
    .global_fsm_s_seq_len           (r1_len),
    .global_fsm_ap_start            (r1_gstart),
    .global_fsm_ap_done             (r1_gdone),
    .task_is_done                   (s1_tdone),
    .perf_cycles                    (r1_perf)
  );

  wire [4:0] w_st  = {idle, ready, gstart, done, gdone};
  wire [4:0] w_st1 = {r1_idle, r1_ready, r1_gstart,
                      r1_done, r1_gdone};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pexp(input int n);
`ifdef GLOBAL_FSM_PERF_CNT_EN
    return 64'(n);
`else
    return 64'(n) & 64'd0;
`endif
  endfunction

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    off      = 64'h0;
    len      = 32'h0;
    tdone    = 4'b0;
    s1_start = 1'b0;
    s1_tdone = 1'b0;
    tick();
    tick();
    chk("rst_state", 64'(w_st), 64'(ST_IDLE));
    rst = 1'b0;
    tick();
    chk("rst_idle", 64'(w_st), 64'(ST_IDLE));
    chk("rst_off", o_off, 64'h0);
    chk("rst_len", 64'(o_len), 64'h0);
    chk("rst_perf", perf, 64'h0);
    chk("rst_st1", 64'(w_st1), 64'(ST_IDLE));

    // single run, done 10 cycles after LAUNCH
    off   = 64'h0000_0001_0000_0000;
    len   = 32'd128;
    start = 1'b1;
    tick();
    chk("r1_launch", 64'(w_st), 64'(ST_LAUNCH));
    chk("r1_off", o_off, 64'h0000_0001_0000_0000);
    chk("r1_len", 64'(o_len), 64'd128);
    start = 1'b0;
    off   = 64'h55;
    len   = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("r1_wait", 64'(w_st), 64'(ST_WAIT));
    end
    tdone = 4'b1111;
    tick();
    chk("r1_finish", 64'(w_st), 64'(ST_FINISH));
    chk("r1_perf", perf, pexp(11));
    tdone = 4'b0;
    tick();
    chk("r1_idle", 64'(w_st), 64'(ST_IDLE));
    chk("r1_off_hold", o_off, 64'h0000_0001_0000_0000);
    chk("r1_len_hold", 64'(o_len), 64'd128);
    chk("r1_perf_hold", perf, pexp(11));

    // staggered done with a dropped bit
    len   = 32'd5;
    start = 1'b1;
    tick();
    chk("r2_launch", 64'(w_st), 64'(ST_LAUNCH));
    start = 1'b0;
    tick();
    tdone = 4'b0001;
    tick();
    chk("r2_w0001", 64'(w_st), 64'(ST_WAIT));
    tdone = 4'b0011;
    tick();
    chk("r2_w0011", 64'(w_st), 64'(ST_WAIT));
    tdone = 4'b0111;
    tick();
    chk("r2_w0111", 64'(w_st), 64'(ST_WAIT));
    tdone = 4'b0101;
    tick();
    chk("r2_w0101", 64'(w_st), 64'(ST_WAIT));
    tdone = 4'b0111;
    tick();
    chk("r2_w0111b", 64'(w_st), 64'(ST_WAIT));
    tdone = 4'b1111;
    tick();
    chk("r2_finish", 64'(w_st), 64'(ST_FINISH));
    chk("r2_perf", perf, pexp(7));
    tdone = 4'b0;
    tick();
    chk("r2_idle", 64'(w_st), 64'(ST_IDLE));

    // start while busy is ignored, then relaunches
    len   = 32'd100;
    start = 1'b1;
    tick();
    chk("r3_launch", 64'(w_st), 64'(ST_LAUNCH));
    start = 1'b0;
    tick();
    start = 1'b1;
    len   = 32'd7;
    tick();
    chk("r3_busy", 64'(w_st), 64'(ST_WAIT));
    chk("r3_len_busy", 64'(o_len), 64'd100);
    tdone = 4'b1111;
    tick();
    chk("r3_finish", 64'(w_st), 64'(ST_FINISH));
    chk("r3_len_fin", 64'(o_len), 64'd100);
    tdone = 4'b0;
    tick();
    chk("r3_idle", 64'(w_st), 64'(ST_IDLE));
    tick();
    chk("r3_relaunch", 64'(w_st), 64'(ST_LAUNCH));
    chk("r3_len_new", 64'(o_len), 64'd7);
    start = 1'b0;
    tick();
    tdone = 4'b1111;
    tick();
    chk("r3_finish2", 64'(w_st), 64'(ST_FINISH));
    tdone = 4'b0;
    tick();

    // reset in the middle of a run
    off   = 64'hABCD;
    len   = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tdone = 4'b0011;
    tick();
    chk("r4_wait", 64'(w_st), 64'(ST_WAIT));
    rst = 1'b1;
    tick();
    chk("r4_rst_st", 64'(w_st), 64'(ST_IDLE));
    chk("r4_rst_off", o_off, 64'h0);
    chk("r4_rst_len", 64'(o_len), 64'h0);
    chk("r4_rst_perf", perf, 64'h0);
    rst   = 1'b0;
    tdone = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r4_no_done", 64'(w_st), 64'(ST_IDLE));
    end

    // stale done during IDLE/LAUNCH
    tick();
    chk("r6_idle", 64'(w_st), 64'(ST_IDLE));
    start = 1'b1;
    tick();
    chk("r6_launch", 64'(w_st), 64'(ST_LAUNCH));
    start = 1'b0;
    tick();
    chk("r6_wait", 64'(w_st), 64'(ST_WAIT));
    tick();
    chk("r6_finish", 64'(w_st), 64'(ST_FINISH));
    chk("r6_perf", perf, pexp(2));
    tdone = 4'b0;
    tick();
    chk("r6_idle2", 64'(w_st), 64'(ST_IDLE));

    // back-to-back, NUM_TASKS=1, start held
    s1_tdone = 1'b1;
    s1_start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("b2b_launch", 64'(w_st1), 64'(ST_LAUNCH));
      tick();
      chk("b2b_wait", 64'(w_st1), 64'(ST_WAIT));
      tick();
      chk("b2b_finish", 64'(w_st1), 64'(ST_FINISH));
      chk("b2b_perf", r1_perf, pexp(2));
      tick();
      chk("b2b_idle", 64'(w_st1), 64'(ST_IDLE));
    end
    s1_start = 1'b0;
    tick();
    chk("b2b_stop", 64'(w_st1), 64'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
